// File: rtl/apb_cmd_master_pkg.sv
// Shared constants and FSM encoding for the APB command master and the UART
// register map that it drives.
package apb_cmd_master_pkg;

    localparam int BITWIDTH = 8;
    localparam int ADDRW    = 2;

    localparam logic [ADDRW-1:0] REG_BAUD = 2'b00;
    localparam logic [ADDRW-1:0] REG_PREC = 2'b01;
    localparam logic [ADDRW-1:0] REG_DATA = 2'b10;
    localparam logic [ADDRW-1:0] REG_CTRL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b10,
        ST_SETUP  = 2'b11
    } state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous show-ahead command FIFO. A push while full is dropped; a pop
// while empty is ignored.
module apb_cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; count/pointers define validity, and
    // resetting the array would only turn plain RAM into flops.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator: queued commands become SETUP/ACCESS transfers, each ending in
// a one-cycle response carrying read data or a PREADY timeout error.
module apb_cmd_master #(
    parameter int BITWIDTH = apb_cmd_master_pkg::BITWIDTH,
    parameter int ADDRW    = apb_cmd_master_pkg::ADDRW,
    parameter int QDEPTH   = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDRW-1:0]    cmd_addr,
    input  logic [BITWIDTH-1:0] cmd_wdata,
    output logic                rsp_valid,
    output logic [BITWIDTH-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDRW-1:0]    PADDR,
    output logic [BITWIDTH-1:0] PWDATA,
    input  logic [BITWIDTH-1:0] PRDATA,
    input  logic                PREADY
);

    import apb_cmd_master_pkg::*;

    localparam int EW = 1 + ADDRW + BITWIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = 1;

    state_e                  state;
    state_e                  next_state;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [EW-1:0]           fifo_head;
    logic [$clog2(QDEPTH):0] fifo_count;
    logic                    head_write;
    logic [ADDRW-1:0]        head_addr;
    logic [BITWIDTH-1:0]     head_wdata;
    logic [TW-1:0]           tcnt;
    logic                    done;
    logic                    abort;

    apb_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETN),
        .push      (cmd_valid),
        .push_data ({cmd_write, cmd_addr, cmd_wdata}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_write = fifo_head[EW-1];
    assign head_addr  = fifo_head[BITWIDTH +: ADDRW];
    assign head_wdata = fifo_head[BITWIDTH-1:0];

    assign cmd_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);

    // NOTE: every signal gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    next_state = ST_SETUP;
                    fifo_pop   = 1'b1;
                end
            end
            ST_SETUP: begin
                next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    done = 1'b1;
                    if (!fifo_empty) begin
                        next_state = ST_SETUP;
                        fifo_pop   = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end else if (tcnt == T_LAST) begin
                    // Abort always passes through IDLE so PSEL drops for a cycle.
                    abort      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state     <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            tcnt      <= '0;
        end else begin
            state     <= next_state;
            PSEL      <= (next_state != ST_IDLE);
            PENABLE   <= (next_state == ST_ACCESS);
            rsp_valid <= done || abort;
            rsp_err   <= abort;
            rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
            if (fifo_pop) begin
                PWRITE <= head_write;
                PADDR  <= head_addr;
                PWDATA <= head_write ? head_wdata : '0;
            end
            if (next_state == ST_SETUP) begin
                tcnt <= '0;
            end else if (state == ST_ACCESS) begin
                tcnt <= tcnt + T_ONE;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed vector table, multi-cycle
// corner sequences, and random traffic against a register-map reference model.
module tb_apb_cmd_master;

    import apb_cmd_master_pkg::*;

    localparam int BW  = 8;
    localparam int AW  = 2;
    localparam int TMO = 16;

    logic          PCLK;
    logic          PRESETN;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [BW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [BW-1:0] PWDATA;
    logic [BW-1:0] PRDATA;
    logic          PREADY;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       write;
        logic [1:0] addr;
        logic [7:0] wdata;
        int         wait_cycles;
        logic [7:0] prdata;
        int         exp_access;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic       write;
        logic [1:0] addr;
        logic [7:0] wdata;
        int         wait_cycles;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } cmd_t;

    cmd_t       apb_q[$];
    cmd_t       rsp_q[$];
    logic [7:0] mmem [4];
    logic [7:0] smem [4];

    apb_cmd_master #(
        .BITWIDTH (BW),
        .ADDRW    (AW),
        .QDEPTH   (4),
        .TIMEOUT  (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic offer(input logic w, input logic [1:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    // One command through an idle master with a scripted slave.
    task automatic run_vec(input vec_t v, input int idx);
        int         acc;
        logic [7:0] exp_pw;
        exp_pw = v.write ? v.wdata : 8'h00;
        PREADY = 1'b0;
        PRDATA = 8'h00;
        offer(v.write, v.addr, v.wdata);
        check($sformatf("vec%0d_ready", idx), 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        check($sformatf("vec%0d_psel_at_accept", idx), 32'(PSEL), 0);
        check($sformatf("vec%0d_busy", idx), 32'(busy), 1);
        tick();
        check($sformatf("vec%0d_setup", idx), {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
              {1'b1, 1'b0, v.write, v.addr, exp_pw});
        tick();
        check($sformatf("vec%0d_penable", idx), 32'(PENABLE), 1);
        acc = 0;
        while (PENABLE && acc < 40) begin
            PREADY = (acc == v.wait_cycles);
            PRDATA = PREADY ? v.prdata : 8'h5A;
            check($sformatf("vec%0d_hold", idx), {PSEL, PWRITE, PADDR, PWDATA},
                  {1'b1, v.write, v.addr, exp_pw});
            acc++;
            tick();
        end
        PREADY = 1'b0;
        check($sformatf("vec%0d_access_cycles", idx), acc, v.exp_access);
        check($sformatf("vec%0d_rsp", idx), {rsp_valid, rsp_err, rsp_rdata, PSEL},
              {1'b1, v.exp_err, v.exp_rdata, 1'b0});
        tick();
        check($sformatf("vec%0d_rsp_pulse_end", idx), {rsp_valid, busy}, 0);
    endtask

    // Four back-to-back writes with PREADY tied high.
    task automatic seq_burst();
        logic [7:0] d [4];
        int   psel_cycles, rises, nrsp, setups;
        logic prev;
        d = '{8'h0D, 8'h00, 8'h9A, 8'h00};
        psel_cycles = 0; rises = 0; nrsp = 0; setups = 0; prev = 1'b0;
        PREADY = 1'b1;
        PRDATA = 8'hE1;
        for (int c = 0; c < 30; c++) begin
            if (c < 4) begin
                offer(1'b1, 2'(c), d[c]);
                check("burst_ready", 32'(cmd_ready), 1);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (PSEL && !prev) rises++;
            if (PSEL) psel_cycles++;
            prev = PSEL;
            if (PSEL && !PENABLE) begin
                if (setups < 4)
                    check("burst_setup_order", {PWRITE, PADDR, PWDATA}, {1'b1, 2'(setups), d[setups]});
                setups++;
            end
            if (rsp_valid) begin
                check("burst_rsp", {rsp_err, rsp_rdata}, 0);
                nrsp++;
            end
        end
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        check("burst_psel_cycles", psel_cycles, 8);
        check("burst_psel_rises", rises, 1);
        check("burst_setups", setups, 4);
        check("burst_rsp_count", nrsp, 4);
    endtask

    // Fill the queue behind a stalled transfer; first command times out,
    // the rest complete once the slave recovers.
    task automatic seq_full_timeout();
        logic       fw [5];
        logic [1:0] fa [5];
        logic [7:0] fd [5];
        int   accepted, nrsp;
        logic take;
        fw = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        fa = '{REG_PREC, REG_BAUD, REG_DATA, REG_CTRL, REG_BAUD};
        fd = '{8'h55, 8'h11, 8'h22, 8'h66, 8'h77};
        accepted = 0; nrsp = 0;
        PREADY = 1'b0;
        PRDATA = 8'hC3;
        for (int c = 0; c < 80 && nrsp < 5; c++) begin
            if (accepted < 5) offer(fw[accepted], fa[accepted], fd[accepted]);
            else cmd_valid = 1'b0;
            take = cmd_valid && cmd_ready;
            tick();
            if (take) begin
                accepted++;
                if (accepted == 5) begin
                    check("full_accept_cycle", c, 4);
                    check("full_ready_low", 32'(cmd_ready), 0);
                end
            end
            if (rsp_valid) begin
                if (nrsp == 0) begin
                    check("timeout_rsp", {rsp_err, rsp_rdata, PSEL, PENABLE}, {1'b1, 8'h00, 1'b0, 1'b0});
                    check("timeout_cycle", c, 18);
                    PREADY = 1'b1;
                end else begin
                    check($sformatf("after_timeout_rsp%0d", nrsp), {rsp_err, rsp_rdata},
                          {1'b0, fw[nrsp] ? 8'h00 : 8'hC3});
                end
                nrsp++;
            end
        end
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        check("full_rsp_count", nrsp, 5);
        tick();
        check("full_drained", {busy, cmd_ready}, 1);
    endtask

    // Reset asserted mid-ACCESS with two commands still queued.
    task automatic seq_reset();
        int spurious, psel_seen;
        spurious = 0; psel_seen = 0;
        PREADY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            offer(1'b1, 2'(c), 8'(8'h30 + c));
            check("rst_push_ready", 32'(cmd_ready), 1);
            tick();
        end
        cmd_valid = 1'b0;
        check("rst_in_access", {PSEL, PENABLE, busy}, 3'b111);
        #2;
        PRESETN = 1'b0;
        #1;
        check("rst_apb_zero", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        check("rst_rsp_zero", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("rst_status", {busy, cmd_ready}, 1);
        @(negedge PCLK);
        PRESETN = 1'b1;
        PREADY  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid) spurious++;
            if (PSEL) psel_seen++;
        end
        PREADY = 1'b0;
        check("rst_no_spurious_rsp", spurious, 0);
        check("rst_no_apb_activity", psel_seen, 0);
        check("rst_idle_status", {busy, cmd_ready}, 1);
    endtask

    // Random commands; expected responses come from a register-map model
    // updated in command order, while the slave keeps its own storage.
    task automatic seq_random();
        cmd_t cur, pend, e;
        bit   have_pend;
        int   issued, nrsp, acnt, cyc;
        logic [7:0] exp_pw;
        have_pend = 0; issued = 0; nrsp = 0; acnt = 0; cyc = 0;
        cur = '{1'b0, 2'b00, 8'h00, 0, 1'b0, 8'h00};
        PREADY = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mmem[i] = 8'h00;
            smem[i] = 8'h00;
        end
        while ((issued < 200 || rsp_q.size() != 0 || busy) && cyc < 20000) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rand_rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rand_rsp", {rsp_err, rsp_rdata}, {e.exp_err, e.exp_rdata});
                    nrsp++;
                end
            end
            if (PSEL && !PENABLE) begin
                if (apb_q.size() == 0) begin
                    check("rand_setup_unexpected", 32'(PSEL), 0);
                end else begin
                    cur = apb_q.pop_front();
                    exp_pw = cur.write ? cur.wdata : 8'h00;
                    check("rand_setup", {PWRITE, PADDR, PWDATA}, {cur.write, cur.addr, exp_pw});
                end
                acnt   = 0;
                PREADY = 1'b0;
            end else if (PSEL && PENABLE) begin
                exp_pw = cur.write ? cur.wdata : 8'h00;
                check("rand_hold", {PWRITE, PADDR, PWDATA}, {cur.write, cur.addr, exp_pw});
                if (acnt == cur.wait_cycles) begin
                    PREADY = 1'b1;
                    if (PWRITE) smem[PADDR] = PWDATA;
                    else PRDATA = smem[PADDR];
                end else begin
                    PREADY = 1'b0;
                    PRDATA = 8'($urandom);
                end
                acnt++;
            end else begin
                PREADY = 1'b0;
            end
            if (!have_pend && issued < 200 && $urandom_range(0, 99) < 80) begin
                pend.write       = 1'($urandom);
                pend.addr        = 2'($urandom);
                pend.wdata       = 8'($urandom);
                pend.wait_cycles = ($urandom_range(0, 99) < 5) ? 17 : int'($urandom_range(0, 3));
                have_pend = 1;
            end
            if (have_pend) offer(pend.write, pend.addr, pend.wdata);
            else cmd_valid = 1'b0;
            if (have_pend && cmd_ready) begin
                pend.exp_err   = (pend.wait_cycles >= TMO);
                pend.exp_rdata = 8'h00;
                if (!pend.exp_err) begin
                    if (pend.write) mmem[pend.addr] = pend.wdata;
                    else pend.exp_rdata = mmem[pend.addr];
                end
                apb_q.push_back(pend);
                rsp_q.push_back(pend);
                issued++;
                have_pend = 0;
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        check("rand_within_budget", 32'(cyc < 20000), 1);
        check("rand_rsp_count", nrsp, 200);
        check("rand_apb_q_empty", apb_q.size(), 0);
    endtask

    initial begin
        vec_t vecs [6];
        vecs[0] = '{1'b1, REG_BAUD, 8'h0D, 0,  8'hFF, 1,  1'b0, 8'h00};
        vecs[1] = '{1'b0, REG_DATA, 8'h77, 3,  8'h9A, 4,  1'b0, 8'h9A};
        vecs[2] = '{1'b0, REG_CTRL, 8'h00, 0,  8'h3C, 1,  1'b0, 8'h3C};
        vecs[3] = '{1'b1, REG_PREC, 8'hA5, 15, 8'h11, 16, 1'b0, 8'h00};
        vecs[4] = '{1'b0, REG_PREC, 8'h42, 16, 8'h66, 16, 1'b1, 8'h00};
        vecs[5] = '{1'b1, REG_CTRL, 8'hC7, 30, 8'h00, 16, 1'b1, 8'h00};

        PRESETN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        #12;
        check("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("reset_status", {busy, cmd_ready}, 1);
        @(negedge PCLK);
        PRESETN = 1'b1;
        tick();
        check("post_reset_idle", {PSEL, busy, cmd_ready}, 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            tick();
        end
        seq_burst();
        tick();
        seq_full_timeout();
        tick();
        seq_reset();
        tick();
        seq_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
